// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERR   = 2'd2
  } state_e;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  // Widest pattern the mask helper supports; PAT_W must stay below this.
  localparam int MASK_MAX  = 64;

  // Ones in the low 'len' bit positions, zeros above.
  function automatic logic [MASK_MAX-1:0] len_mask(input int unsigned len);
    logic [MASK_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter; clear wins over a simultaneous increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;
  assign sat = &r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (1..PAT_W bits) with
// overlap control, registered match pulse and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = PAT_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             overlap_in,
  input  logic             din_valid,
  input  logic             din_bit,
  input  logic             cnt_clr,
  output logic             dout_bit,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             cfg_err,
  output logic             armed,
  output logic [1:0]       dbg_state
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  state_e              r_state;
  state_e              w_next_state;
  logic [PAT_W-1:0]    r_pat;
  logic [PAT_W-1:0]    r_hist;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_fill;
  logic                r_overlap;
  logic                r_match_q;

  logic                w_cfg_ok;
  logic                w_shift;
  logic                w_fill_ok;
  logic                w_hit;
  logic [PAT_W-1:0]    w_window;
  logic [MASK_MAX-1:0] w_mask_full;
  logic [PAT_W-1:0]    w_mask;
  logic [MASK_MAX-PAT_W:0] w_unused;

  assign w_cfg_ok    = (len_in != '0) && (len_in <= PAT_W_L);
  assign w_shift     = (r_state == ST_RUN) && din_valid && !cfg_load;
  assign w_window    = {r_hist[PAT_W-2:0], din_bit};
  assign w_mask_full = len_mask(32'(r_len));
  assign w_mask      = w_mask_full[PAT_W-1:0];
  // Oldest history bit only ever shifts out; upper mask bits lie beyond PAT_W.
  assign w_unused    = {w_mask_full[MASK_MAX-1:PAT_W], r_hist[PAT_W-1]};

  // fill counts bits already held in hist; the presented bit makes one more.
  assign w_fill_ok = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len};
  assign w_hit     = w_shift && w_fill_ok && ((w_window & w_mask) == (r_pat & w_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_UNCFG;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (cfg_load) begin
      w_next_state = w_cfg_ok ? ST_RUN : ST_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match_q <= 1'b0;
    end else begin
      r_match_q <= w_hit;
      if (cfg_load) begin
        r_hist <= '0;
        r_fill <= '0;
        if (w_cfg_ok) begin
          r_pat     <= pat_in;
          r_len     <= len_in;
          r_overlap <= overlap_in;
        end
      end else if (w_shift) begin
        r_hist <= w_window;
        // Non-overlapping mode forgets progress so the next match needs len fresh bits.
        if (w_hit && !r_overlap) begin
          r_fill <= '0;
        end else if (r_fill != PAT_W_L) begin
          r_fill <= r_fill + LEN_W'(1);
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (w_hit),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

  assign dout_bit  = w_hit;
  assign match_q   = r_match_q;
  assign armed     = (r_state == ST_RUN);
  assign cfg_err   = (r_state == ST_ERR);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: vector table plus hand sequences
// for saturation, clear priority and mid-stream reset.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       overlap_in;
  logic       din_valid;
  logic       din_bit;
  logic       cnt_clr;

  logic       dout_bit, match_q, cnt_sat, cfg_err, armed;
  logic [7:0] match_cnt;
  logic [1:0] dbg_state;
  logic       dout_bit2, match_q2, cnt_sat2, cfg_err2, armed2;
  logic [1:0] match_cnt2;
  logic [1:0] dbg_state2;

  int checks = 0;
  int errors = 0;
  logic prev_d = 1'b0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .pat_in(pat_in), .len_in(len_in),
    .overlap_in(overlap_in), .din_valid(din_valid), .din_bit(din_bit), .cnt_clr(cnt_clr),
    .dout_bit(dout_bit), .match_q(match_q), .match_cnt(match_cnt), .cnt_sat(cnt_sat),
    .cfg_err(cfg_err), .armed(armed), .dbg_state(dbg_state)
  );

  seq_detector_param #(.PAT_W(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .pat_in(pat_in), .len_in(len_in),
    .overlap_in(overlap_in), .din_valid(din_valid), .din_bit(din_bit), .cnt_clr(cnt_clr),
    .dout_bit(dout_bit2), .match_q(match_q2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2),
    .cfg_err(cfg_err2), .armed(armed2), .dbg_state(dbg_state2)
  );

  typedef struct {
    logic       cl;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       v;
    logic       b;
    logic       clr;
    logic       ed;
    logic       ea;
    logic       ee;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then settle before sampling.
  task automatic drive(input logic cl, input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic v, input logic b, input logic c);
    @(negedge clk);
    cfg_load = cl; pat_in = p; len_in = l; overlap_in = o;
    din_valid = v; din_bit = b; cnt_clr = c;
    #1;
  endtask

  task automatic push(input logic cl, input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic v, input logic b, input logic c,
                      input logic ed, input logic ea, input logic ee, input logic [7:0] ec);
    vec_t t;
    t.cl = cl; t.pat = p; t.len = l; t.ov = o; t.v = v; t.b = b; t.clr = c;
    t.ed = ed; t.ea = ea; t.ee = ee; t.ec = ec;
    vecs.push_back(t);
  endtask

  task automatic bit_row(input logic b, input logic ed, input logic ea, input logic ee,
                         input logic [7:0] ec);
    push(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, 1'b0, ed, ea, ee, ec);
  endtask

  task automatic idle_row(input logic ea, input logic ee, input logic [7:0] ec);
    push(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ea, ee, ec);
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; pat_in = '0; len_in = '0; overlap_in = 1'b0;
    din_valid = 1'b0; din_bit = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_armed", 32'(armed), 0);
    chk("reset_cfg_err", 32'(cfg_err), 0);
    chk("reset_cnt", 32'(match_cnt), 0);
    chk("reset_match_q", 32'(match_q), 0);
    chk("reset_state", 32'(dbg_state), 0);

    // Overlapping 0110: stream 0110110 hits on bits 4 and 7.
    push(1, 8'h06, 4'd4, 1, 0, 0, 0, 0, 0, 0, 0);
    bit_row(0, 0, 1, 0, 0); bit_row(1, 0, 1, 0, 0); bit_row(1, 0, 1, 0, 0);
    bit_row(0, 1, 1, 0, 0); bit_row(1, 0, 1, 0, 1); bit_row(1, 0, 1, 0, 1);
    bit_row(0, 1, 1, 0, 1); idle_row(1, 0, 2);
    // Non-overlapping, counter cleared alongside the reload.
    push(1, 8'h06, 4'd4, 0, 0, 0, 1, 0, 1, 0, 2);
    bit_row(0, 0, 1, 0, 0); bit_row(1, 0, 1, 0, 0); bit_row(1, 0, 1, 0, 0);
    bit_row(0, 1, 1, 0, 0); bit_row(1, 0, 1, 0, 1); bit_row(1, 0, 1, 0, 1);
    bit_row(0, 0, 1, 0, 1); idle_row(1, 0, 1);
    // Invalid lengths 0 and 9, then a valid 3-bit pattern 110.
    push(1, 8'h06, 4'd0, 1, 0, 0, 0, 0, 1, 0, 1);
    bit_row(0, 0, 0, 1, 1); bit_row(1, 0, 0, 1, 1); bit_row(1, 0, 0, 1, 1); bit_row(0, 0, 0, 1, 1);
    push(1, 8'h06, 4'd9, 1, 0, 0, 0, 0, 0, 1, 1);
    bit_row(0, 0, 0, 1, 1); bit_row(1, 0, 0, 1, 1); bit_row(1, 0, 0, 1, 1); bit_row(0, 0, 0, 1, 1);
    push(1, 8'h06, 4'd3, 1, 0, 0, 0, 0, 0, 1, 1);
    bit_row(1, 0, 1, 0, 1); bit_row(1, 0, 1, 0, 1); bit_row(0, 1, 1, 0, 1); idle_row(1, 0, 2);
    // Gaps in din_valid, then a reload on what would be a match cycle.
    push(1, 8'h06, 4'd4, 1, 0, 0, 0, 0, 1, 0, 2);
    bit_row(0, 0, 1, 0, 2); idle_row(1, 0, 2); bit_row(1, 0, 1, 0, 2); idle_row(1, 0, 2);
    bit_row(1, 0, 1, 0, 2); idle_row(1, 0, 2); bit_row(0, 1, 1, 0, 2);
    bit_row(1, 0, 1, 0, 3); bit_row(1, 0, 1, 0, 3);
    push(1, 8'h06, 4'd4, 1, 1, 0, 0, 0, 1, 0, 3);
    bit_row(1, 0, 1, 0, 3); bit_row(1, 0, 1, 0, 3); bit_row(0, 0, 1, 0, 3);
    bit_row(1, 0, 1, 0, 3); bit_row(1, 0, 1, 0, 3); bit_row(0, 1, 1, 0, 3);
    idle_row(1, 0, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cl, vecs[i].pat, vecs[i].len, vecs[i].ov, vecs[i].v, vecs[i].b, vecs[i].clr);
      chk($sformatf("v%0d_dout", i), 32'(dout_bit), 32'(vecs[i].ed));
      chk($sformatf("v%0d_match_q", i), 32'(match_q), 32'(prev_d));
      chk($sformatf("v%0d_armed", i), 32'(armed), 32'(vecs[i].ea));
      chk($sformatf("v%0d_cfg_err", i), 32'(cfg_err), 32'(vecs[i].ee));
      chk($sformatf("v%0d_cnt", i), 32'(match_cnt), 32'(vecs[i].ec));
      prev_d = vecs[i].ed;
    end

    // 2-bit counter: saturated from the earlier matches, then len=1 ones.
    drive(1, 8'h01, 4'd1, 0, 0, 0, 1);
    chk("sat_pre_cnt2", 32'(match_cnt2), 3);
    chk("sat_pre_flag2", 32'(cnt_sat2), 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
      chk($sformatf("sat_dout_%0d", k), 32'(dout_bit2), 1);
      chk($sformatf("sat_cnt_%0d", k), 32'(match_cnt2), (k > 3) ? 3 : k);
      chk($sformatf("sat_flag_%0d", k), 32'(cnt_sat2), (k >= 3) ? 1 : 0);
    end
    drive(0, 8'h00, 4'd0, 0, 0, 0, 0);
    chk("sat_final_cnt", 32'(match_cnt2), 3);
    chk("sat_final_flag", 32'(cnt_sat2), 1);
    drive(0, 8'h00, 4'd0, 0, 1, 1, 1);
    chk("clr_hit_dout", 32'(dout_bit2), 1);
    drive(0, 8'h00, 4'd0, 0, 0, 0, 0);
    chk("clr_hit_cnt", 32'(match_cnt2), 0);
    chk("clr_hit_flag", 32'(cnt_sat2), 0);
    chk("clr_hit_cnt8", 32'(match_cnt), 0);

    // Mid-pattern reset, including a would-be final bit during reset.
    drive(1, 8'h06, 4'd4, 1, 0, 0, 0);
    drive(0, 8'h00, 4'd0, 0, 1, 0, 0);
    drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
    drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
    chk("pre_rst_cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b1; din_bit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_armed", 32'(armed), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_match_q", 32'(match_q), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_dout", 32'(dout_bit), 0);
    drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
    chk("rst_dout_b1", 32'(dout_bit), 0);
    drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
    drive(0, 8'h00, 4'd0, 0, 1, 0, 0);
    chk("rst_dout_b3", 32'(dout_bit), 0);
    chk("rst_state", 32'(dbg_state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
